mem_req_shaper: RTL and testbench
=================================

# mem_req_shaper

Front-end conditioning stage sitting directly upstream of the memory access controller. It turns level-style "want memory" and "finished" signals from the three bus masters (M1, M2, M3) into the single-cycle `req[n]` / `done[n]` pulses the controller consumes. It tracks the controller's `accmodule` grant to know which master owns memory. It guarantees the controller's input rules by construction:
- `req[n]` and `done[n]` are one-cycle pulses.
- `req[n]` and `done[n]` are never high in the same cycle.
- `done[n]` is issued only by the current owner.

## Interface
Parameters:
- `TIMEOUT`, 8, cycles a master waits in WAIT without a grant before its request is re-issued (legal range 2..2^CNT_W-1).
- `CNT_W`, 4, width of the retry and preempt statistics counters.

Ports:
- `clk` input 1: single clock; all logic is on the rising edge.
- `reset_n` input 1: synchronous, active-low reset.
- `want` input 3: level; bit n high means master n wants memory. Sampled only while master n is in IDLE.
- `fin` input 3: master n has finished its transfer. Honoured only while master n is in OWN.
- `accmodule` input 2: current owner from the controller (0 none, 1 M1, 2 M2, 3 M3). Master n corresponds to `accmodule == n+1`.
- `req` output 3: one-cycle request pulses to the controller.
- `done` output 3: one-cycle release pulses to the controller.
- `granted` output 3: registered; high while master n is in OWN.
- `retries` output CNT_W: saturating count of timeout re-requests, summed over all masters.
- `preempts` output CNT_W: saturating count of OWN→WAIT losses without `done`, summed over all masters.

## Operation
- Three identical, independent per-master FSMs. States: IDLE, REQ, WAIT, OWN, DONE. Each FSM has a wait counter of ceil(log2(TIMEOUT)) bits.
- Outputs decode directly from state registers, so every output is glitch-free and registered:
  - `req[n]` = (state==REQ)
  - `done[n]` = (state==DONE)
  - `granted[n]` = (state==OWN)
- Transitions per master n; "own" means `accmodule == n+1`:
  - IDLE: if `want[n]`, go to REQ; otherwise stay.
  - REQ: always go to WAIT and clear the wait counter.
  - WAIT: if own, go to OWN. Else if wait counter == TIMEOUT-1, go to REQ and increment `retries`. Else increment the wait counter. Grant has priority over timeout.
  - OWN: if own and `fin[n]`, go to DONE. Else if not own, go to WAIT, clear the wait counter and increment `preempts`; `fin[n]` is ignored in this cycle. Otherwise stay.
  - DONE: always go to IDLE. IDLE lasts at least one cycle, so `req[n]` is never high in back-to-back cycles.
- Invariants:
  - REQ and DONE are always left after one cycle, so `req` and `done` are exact one-cycle pulses.
  - REQ and DONE are distinct states, so `req[n] & done[n]` is always 0.
  - DONE is reachable only from OWN with `accmodule == n+1`.
- `want[n]` is ignored in every state except IDLE. A master cannot withdraw a request; it must complete through `fin`.
- Statistics counters:
  - Saturate at 2^CNT_W-1.
  - If several masters trigger the same counter in one cycle, add the number of triggers, with saturation.
- Reset: with `reset_n == 0` at a rising edge, all FSMs go to IDLE and wait counters, `retries` and `preempts` clear. This applies in any state, including mid-REQ or mid-OWN.

## Timing
- Reset values: `req`=0, `done`=0, `granted`=0, `retries`=0, `preempts`=0.
- `want[n]` sampled high at edge t → `req[n]`=1 for the cycle t..t+1 only.
- Grant seen at edge t (state WAIT, own) → `granted[n]`=1 from t.
- `fin[n]` sampled at edge t while OWN and own → `done[n]`=1 for t..t+1 and `granted[n]`=0 from t. Master n may re-request no earlier than edge t+2, giving `req` at t+2..t+3.
- Retry: with no grant, the first `req` pulse is followed by a retry pulse TIMEOUT+1 cycles later.
- All three masters may pulse `req` in the same cycle; the block does not arbitrate.

## Test plan
- Reset: hold `reset_n`=0 for 2 cycles with random inputs → all outputs 0. Assert `reset_n`=0 while M2 is in OWN → next cycle `granted`=000 and no `done` pulse.
- Basic cycle: `want`=001, `accmodule`=1 two cycles after `req[0]`, `fin[0]` after 3 owned cycles → `req`=001 for exactly 1 cycle, `granted[0]`=1 for 3 cycles, `done`=001 for exactly 1 cycle, `retries`=0.
- Timeout: `want[1]`=1, `accmodule` held 0 for 20 cycles, TIMEOUT=8 → `req[1]` pulses at cycles 1, 10, 19; `retries`=2.
- Preemption: M3 in OWN, `accmodule` goes 3→1 → `granted[2]` drops, `preempts`=1, no `done[2]`. `accmodule` back to 3 → `granted[2]`=1. Then `fin[2]` → `done[2]` pulse.
- Fin vs. loss race: `fin[1]`=1 in the same cycle `accmodule` changes 2→3 → no `done[1]`, state WAIT, `preempts` increments.
- Saturation and simultaneity: all three `want` high with no grant for 200 cycles → `req`=111 pulses together, `retries` saturates at 15 and holds; `req & done` never nonzero.

Source files
------------

// File: rtl/mem_req_shaper.sv
// rtl/mem_req_shaper.sv - per-master request/release pulse shaper in front of the memory access controller
//
// Purpose: turns level-style want/fin signals from three bus masters into
// one-cycle req/done pulses. Ownership is tracked from the controller's
// accmodule grant. A request that is not granted is re-issued after TIMEOUT
// cycles.
//
// Ports:
//   clk        - rising-edge clock
//   reset_n    - synchronous active-low reset
//   want[2:0]  - level, master n wants memory (sampled only in IDLE)
//   fin[2:0]   - master n finished (honoured only in OWN while owner)
//   accmodule  - current owner: 0 none, n+1 = master n
//   req[2:0]   - one-cycle request pulses
//   done[2:0]  - one-cycle release pulses
//   granted    - high while master n is in OWN
//   retries    - saturating count of timeout re-requests (all masters)
//   preempts   - saturating count of ownership losses without done (all masters)

module mem_req_shaper #(
    parameter int TIMEOUT = 8,
    parameter int CNT_W   = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       want,
    input  logic [2:0]       fin,
    input  logic [1:0]       accmodule,
    output logic [2:0]       req,
    output logic [2:0]       done,
    output logic [2:0]       granted,
    output logic [CNT_W-1:0] retries,
    output logic [CNT_W-1:0] preempts
);

    localparam int WC_W = $clog2(TIMEOUT);
    localparam logic [WC_W-1:0]  WC_LAST = WC_W'(TIMEOUT - 1);
    localparam logic [CNT_W+1:0] SAT_W   = {2'b00, {CNT_W{1'b1}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_OWN,
        S_DONE
    } state_t;

    state_t          state_q [3];
    state_t          state_d [3];
    logic [WC_W-1:0] wcnt_q  [3];
    logic [WC_W-1:0] wcnt_d  [3];

    logic [CNT_W-1:0] retries_q, retries_d;
    logic [CNT_W-1:0] preempts_q, preempts_d;

    logic [2:0]       own;
    logic [2:0]       retry_hit;
    logic [2:0]       preempt_hit;
    logic [CNT_W+1:0] retries_sum;
    logic [CNT_W+1:0] preempts_sum;

    assign own = {accmodule == 2'd3, accmodule == 2'd2, accmodule == 2'd1};

    // Per-master next-state logic; the three FSMs never interact.
    always_comb begin
        retry_hit   = 3'b000;
        preempt_hit = 3'b000;
        for (int n = 0; n < 3; n++) begin
            state_d[n] = state_q[n];
            wcnt_d[n]  = wcnt_q[n];
            case (state_q[n])
                S_IDLE: begin
                    if (want[n]) begin
                        state_d[n] = S_REQ;
                    end
                end
                S_REQ: begin
                    state_d[n] = S_WAIT;
                    wcnt_d[n]  = '0;
                end
                S_WAIT: begin
                    // A grant wins over a timeout landing in the same cycle.
                    if (own[n]) begin
                        state_d[n] = S_OWN;
                    end else if (wcnt_q[n] == WC_LAST) begin
                        state_d[n]   = S_REQ;
                        retry_hit[n] = 1'b1;
                    end else begin
                        wcnt_d[n] = wcnt_q[n] + 1'b1;
                    end
                end
                S_OWN: begin
                    // Losing the grant dominates fin: a done pulse is only
                    // ever issued by the current owner.
                    if (!own[n]) begin
                        state_d[n]     = S_WAIT;
                        wcnt_d[n]      = '0;
                        preempt_hit[n] = 1'b1;
                    end else if (fin[n]) begin
                        state_d[n] = S_DONE;
                    end
                end
                S_DONE: begin
                    state_d[n] = S_IDLE;
                end
                default: begin
                    state_d[n] = S_IDLE;
                end
            endcase
        end
    end

    // Statistics: add the number of simultaneous triggers, then clamp.
    always_comb begin
        retries_sum  = {2'b00, retries_q}
                     + (CNT_W+2)'(retry_hit[0])
                     + (CNT_W+2)'(retry_hit[1])
                     + (CNT_W+2)'(retry_hit[2]);
        preempts_sum = {2'b00, preempts_q}
                     + (CNT_W+2)'(preempt_hit[0])
                     + (CNT_W+2)'(preempt_hit[1])
                     + (CNT_W+2)'(preempt_hit[2]);
        retries_d    = (retries_sum > SAT_W) ? {CNT_W{1'b1}} : retries_sum[CNT_W-1:0];
        preempts_d   = (preempts_sum > SAT_W) ? {CNT_W{1'b1}} : preempts_sum[CNT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int n = 0; n < 3; n++) begin
                state_q[n] <= S_IDLE;
                wcnt_q[n]  <= '0;
            end
            retries_q  <= '0;
            preempts_q <= '0;
        end else begin
            for (int n = 0; n < 3; n++) begin
                state_q[n] <= state_d[n];
                wcnt_q[n]  <= wcnt_d[n];
            end
            retries_q  <= retries_d;
            preempts_q <= preempts_d;
        end
    end

    // Outputs decode straight from state flops, so they are registered.
    always_comb begin
        req     = 3'b000;
        done    = 3'b000;
        granted = 3'b000;
        for (int n = 0; n < 3; n++) begin
            req[n]     = (state_q[n] == S_REQ);
            done[n]    = (state_q[n] == S_DONE);
            granted[n] = (state_q[n] == S_OWN);
        end
    end

    assign retries  = retries_q;
    assign preempts = preempts_q;

endmodule

// File: tb/tb_mem_req_shaper.sv
// tb/tb_mem_req_shaper.sv - directed self-checking bench for mem_req_shaper

module tb_mem_req_shaper;

    logic       clk;
    logic       reset_n;
    logic [2:0] want;
    logic [2:0] fin;
    logic [1:0] accmodule;
    logic [2:0] req;
    logic [2:0] done;
    logic [2:0] granted;
    logic [3:0] retries;
    logic [3:0] preempts;

    int checks;
    int errors;

    mem_req_shaper #(
        .TIMEOUT (8),
        .CNT_W   (4)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .want      (want),
        .fin       (fin),
        .accmodule (accmodule),
        .req       (req),
        .done      (done),
        .granted   (granted),
        .retries   (retries),
        .preempts  (preempts)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int exp_ret;
        checks    = 0;
        errors    = 0;
        reset_n   = 1'b0;
        want      = 3'($urandom);
        fin       = 3'($urandom);
        accmodule = 2'($urandom);

        // Reset with random inputs
        tick(1);
        want      = 3'($urandom);
        fin       = 3'($urandom);
        accmodule = 2'($urandom);
        tick(1);
        chk("rst_req",      32'(req),      32'h0);
        chk("rst_done",     32'(done),     32'h0);
        chk("rst_granted",  32'(granted),  32'h0);
        chk("rst_retries",  32'(retries),  32'h0);
        chk("rst_preempts", 32'(preempts), 32'h0);
        want = 3'b000; fin = 3'b000; accmodule = 2'd0; reset_n = 1'b1;
        tick(1);
        chk("idle_req", 32'(req), 32'h0);

        // Basic cycle on M1
        want = 3'b001;
        tick(1);
        chk("basic_req_pulse", 32'(req), 32'h1);
        want = 3'b000;
        tick(1);
        chk("basic_req_gone", 32'(req), 32'h0);
        accmodule = 2'd1;
        tick(1);
        chk("basic_grant1", 32'(granted), 32'h1);
        tick(1);
        chk("basic_grant2", 32'(granted), 32'h1);
        tick(1);
        chk("basic_grant3", 32'(granted), 32'h1);
        fin = 3'b001;
        tick(1);
        chk("basic_done_pulse", 32'(done),    32'h1);
        chk("basic_grant_off",  32'(granted), 32'h0);
        fin = 3'b000;
        tick(1);
        chk("basic_done_gone", 32'(done),    32'h0);
        chk("basic_retries",   32'(retries), 32'h0);
        accmodule = 2'd0;

        // Timeout re-requests on M2
        want = 3'b010;
        tick(1);
        chk("to_req1", 32'(req), 32'h2);
        want = 3'b000;
        tick(8);
        chk("to_gap1", 32'(req), 32'h0);
        tick(1);
        chk("to_req2",     32'(req),     32'h2);
        chk("to_retries1", 32'(retries), 32'h1);
        tick(8);
        chk("to_gap2", 32'(req), 32'h0);
        tick(1);
        chk("to_req3",     32'(req),     32'h2);
        chk("to_retries2", 32'(retries), 32'h2);

        // Reset while M2 owns memory
        accmodule = 2'd2;
        tick(2);
        chk("to_granted", 32'(granted), 32'h2);
        reset_n = 1'b0;
        tick(1);
        chk("midown_rst_granted", 32'(granted), 32'h0);
        chk("midown_rst_done",    32'(done),    32'h0);
        chk("midown_rst_retries", 32'(retries), 32'h0);
        reset_n = 1'b1; accmodule = 2'd0;

        // Preemption of M3
        want = 3'b100; accmodule = 2'd3;
        tick(1);
        chk("pre_req", 32'(req), 32'h4);
        want = 3'b000;
        tick(2);
        chk("pre_own", 32'(granted), 32'h4);
        accmodule = 2'd1;
        tick(1);
        chk("pre_lost_granted", 32'(granted),  32'h0);
        chk("pre_lost_done",    32'(done),     32'h0);
        chk("pre_count1",       32'(preempts), 32'h1);
        accmodule = 2'd3;
        tick(1);
        chk("pre_regrant", 32'(granted), 32'h4);
        fin = 3'b100;
        tick(1);
        chk("pre_done", 32'(done), 32'h4);
        fin = 3'b000; accmodule = 2'd0;
        tick(1);
        chk("pre_done_gone", 32'(done), 32'h0);

        // fin racing with loss of grant on M2
        want = 3'b010; accmodule = 2'd2;
        tick(3);
        chk("race_own", 32'(granted), 32'h2);
        want = 3'b000; fin = 3'b010; accmodule = 2'd3;
        tick(1);
        chk("race_no_done",  32'(done),     32'h0);
        chk("race_granted",  32'(granted),  32'h0);
        chk("race_preempts", 32'(preempts), 32'h2);
        fin = 3'b000; accmodule = 2'd2;
        tick(1);
        chk("race_in_wait", 32'(granted), 32'h2);
        // Re-request held high across done: req comes two edges after done
        fin = 3'b010; want = 3'b010;
        tick(1);
        chk("race_done", 32'(done), 32'h2);
        fin = 3'b000;
        tick(1);
        chk("rereq_blocked", 32'(req), 32'h0);
        tick(1);
        chk("rereq_pulse", 32'(req), 32'h2);
        chk("race_retries", 32'(retries), 32'h0);

        // Saturation and simultaneity
        reset_n = 1'b0; want = 3'b000; accmodule = 2'd0;
        tick(1);
        reset_n = 1'b1; want = 3'b111;
        for (int i = 0; i < 200; i++) begin
            tick(1);
            exp_ret = 3 * (i / 9);
            if (exp_ret > 15) exp_ret = 15;
            chk($sformatf("sat_req_%0d", i), 32'(req), (i % 9 == 0) ? 32'h7 : 32'h0);
            chk($sformatf("sat_retries_%0d", i), 32'(retries), 32'(exp_ret));
            chk($sformatf("sat_reqdone_%0d", i), 32'(req & done), 32'h0);
        end
        chk("sat_preempts", 32'(preempts), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
